// File: rtl/booth_mul_seq_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM state
// encodings, Booth operation codes and the recoding helper.
package booth_mul_seq_pkg;

    // Operand width; the downstream adder is fixed at 32 bits.
    localparam int MUL_WIDTH = 32;
    // Iteration counter width; 2**MUL_CNT_W must exceed MUL_WIDTH.
    localparam int MUL_CNT_W = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

    // Radix-2 Booth recoding of the multiplier bit pair {Q[0], q_1}.
    function automatic booth_op_t booth_decode(input logic q0, input logic q_1);
        booth_op_t op;
        case ({q0, q_1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/add.sv
// 32-bit ripple-carry adder shared with the ALU; computes a + b + cin.
module add (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [32:0] carry;

    assign carry[0] = cin;

    // One full-adder cell per bit, carry rippling from bit 0 upwards.
    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_fa
            assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
            assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
        end
    endgenerate

    assign cout = carry[32];

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: signed 32x32 -> 64-bit product
// delivered on hi/lo, one Booth iteration per clock through a single
// shared ripple-carry adder.
module booth_mul_seq
    import booth_mul_seq_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH,   // only 32 works: the adder is fixed-width
    parameter int CNT_W = MUL_CNT_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Architectural state
    state_t           state_q, state_d;
    logic [WIDTH-1:0] m_q,     m_d;       // latched multiplicand
    logic [WIDTH-1:0] acc_q,   acc_d;     // A: upper half of the running product
    logic [WIDTH-1:0] q_q,     q_d;       // Q: multiplier, shifting into the lower half
    logic             q1_q,    q1_d;      // bit shifted out of Q on the previous step
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] hi_q,    hi_d;
    logic [WIDTH-1:0] lo_q,    lo_d;

    // Datapath for one iteration
    booth_op_t        op;
    logic [WIDTH-1:0] add_b;
    logic             add_cin;
    logic [WIDTH-1:0] add_sum;
    logic             add_cout_unused;
    logic [WIDTH-1:0] s_val;
    logic             ovf;
    logic             sgn;

    add u_add (
        .a    (acc_q),
        .b    (add_b),
        .cin  (add_cin),
        .sum  (add_sum),
        .cout (add_cout_unused)
    );

    // Operand select for the adder and the true sign of the partial sum.
    // The sign fed into the arithmetic shift is corrected for signed
    // overflow so that M = -2^31 still produces the right product.
    always_comb begin
        op      = booth_decode(q_q[0], q1_q);
        add_b   = m_q;
        add_cin = 1'b0;
        s_val   = acc_q;
        ovf     = 1'b0;
        sgn     = acc_q[WIDTH-1];
        case (op)
            BOOTH_ADD: begin
                add_b   = m_q;
                add_cin = 1'b0;
                s_val   = add_sum;
                ovf     = (acc_q[WIDTH-1] == m_q[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
                sgn     = add_sum[WIDTH-1] ^ ovf;
            end
            BOOTH_SUB: begin
                add_b   = ~m_q;
                add_cin = 1'b1;
                s_val   = add_sum;
                ovf     = (acc_q[WIDTH-1] == ~m_q[WIDTH-1]) &&
                          (add_sum[WIDTH-1] != acc_q[WIDTH-1]);
                sgn     = add_sum[WIDTH-1] ^ ovf;
            end
            default: begin
                s_val = acc_q;
                sgn   = acc_q[WIDTH-1];
            end
        endcase
    end

    // Next-state logic: load on start, iterate/shift in RUN, publish result.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q1_d    = q1_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    m_d     = a;
                    acc_d   = '0;
                    q_d     = b;
                    q1_d    = 1'b0;
                    count_d = CNT_W'(WIDTH);
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // {A,Q,q_1} <= {sgn, S, Q} >> 1
                acc_d   = {sgn, s_val[WIDTH-1:1]};
                q_d     = {s_val[0], q_q[WIDTH-1:1]};
                q1_d    = q_q[0];
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    hi_d    = acc_d;
                    lo_d    = q_d;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State register with asynchronous clear of every flop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q1_q    <= 1'b0;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q1_q    <= q1_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: expected products are queued at
// issue time from a plain 64-bit signed multiply; a monitor pops and
// compares whenever done is presented.
module tb_booth_mul_seq;

    logic        clock   = 1'b0;
    logic        reset_n = 1'b0;
    logic        start   = 1'b0;
    logic [31:0] a       = '0;
    logic [31:0] b       = '0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          errors     = 0;
    int          checks     = 0;
    int          done_count = 0;
    logic [63:0] sb[$];

    booth_mul_seq dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return 64'(p);
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && done) begin
            done_count++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got hi=%h lo=%h expected no completion", hi, lo);
            end else begin
                logic [63:0] e;
                e = sb.pop_front();
                check64("product", {hi, lo}, e);
                $display("txn done: hi=%h lo=%h expected %h", hi, lo, e);
            end
        end
    end

    // Issue one operation, scramble inputs after the start edge, and verify
    // latency, post-completion idle and result hold.
    task automatic run_op(input logic [31:0] x, input logic [31:0] y, input string name);
        int cyc;
        @(negedge clock);
        a = x; b = y; start = 1'b1;
        sb.push_back(ref_mul(x, y));
        $display("txn issue %s: a=%h b=%h", name, x, y);
        @(posedge clock); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        cyc = 0;
        while (!done && cyc < 100) begin
            @(posedge clock); #1;
            cyc++;
        end
        check64({name, "_latency"}, 64'(cyc), 64'd32);
        @(posedge clock); #1;
        check64({name, "_idle_after"}, {62'd0, busy, done}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check64({name, "_hold"}, {hi, lo}, ref_mul(x, y));
    endtask

    initial begin
        logic [63:0] e;
        int          base;
        int          cyc;

        // Reset state
        #12;
        check64("reset_flags", {62'd0, busy, done}, 64'd0);
        check64("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clock);
        reset_n = 1'b1;

        // Directed cases
        run_op(32'd6,          32'd7,          "t1_6x7");
        run_op(32'hFFFFFFFD,   32'd5,          "t2_m3x5");
        run_op(32'h80000000,   32'hFFFFFFFF,   "t3_min_x_m1");
        run_op(32'h80000000,   32'h80000000,   "t4_min_x_min");
        run_op(32'h7FFFFFFF,   32'h7FFFFFFF,   "t4_max_x_max");
        run_op(32'h7FFFFFFF,   32'h80000000,   "t4_max_x_min");
        run_op(32'd0,          32'hFFFFFFFF,   "t_zero");

        // Start while busy is ignored
        base = done_count;
        @(negedge clock);
        a = 32'd2; b = 32'd3; start = 1'b1;
        sb.push_back(ref_mul(32'd2, 32'd3));
        $display("txn issue t5_first: a=2 b=3");
        @(posedge clock); #1; start = 1'b0;
        repeat (4) @(posedge clock);
        @(negedge clock);
        a = 32'd9; b = 32'd9; start = 1'b1;
        $display("txn issue t5_ignored: a=9 b=9 while busy");
        @(posedge clock); #1; start = 1'b0;
        cyc = 0;
        while (done_count == base && cyc < 100) begin
            @(negedge clock);
            cyc++;
        end
        repeat (40) @(posedge clock);
        #1;
        check64("t5_done_pulses", 64'(done_count - base), 64'd1);
        check64("t5_result", {hi, lo}, 64'd6);

        // Start held high: back-to-back operations
        base = done_count;
        @(negedge clock);
        a = 32'hFFFFFF00; b = 32'd300; start = 1'b1;
        sb.push_back(ref_mul(32'hFFFFFF00, 32'd300));
        sb.push_back(ref_mul(32'hFFFFFF00, 32'd300));
        $display("txn issue t_held: a=ffffff00 b=300 twice");
        cyc = 0;
        while (done_count < base + 2 && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        start = 1'b0;
        repeat (40) @(posedge clock);
        #1;
        check64("t_held_done_pulses", 64'(done_count - base), 64'd2);
        check64("t_held_cycles", 64'(cyc > 60 && cyc < 72), 64'd1);

        // Reset in the middle of RUN abandons the operation
        @(negedge clock);
        a = 32'd5; b = 32'd7; start = 1'b1;
        sb.push_back(ref_mul(32'd5, 32'd7));
        $display("txn issue t6_aborted: a=5 b=7");
        @(posedge clock); #1; start = 1'b0;
        repeat (10) @(posedge clock);
        #2;
        reset_n = 1'b0;
        #1;
        check64("t6_reset_flags", {62'd0, busy, done}, 64'd0);
        check64("t6_reset_hilo", {hi, lo}, 64'd0);
        sb.delete();
        @(negedge clock);
        reset_n = 1'b1;
        run_op(32'd4, 32'hFFFFFFFC, "t6_4xm4");

        // Randomized operations with occasional corner operands
        for (int i = 0; i < 16; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 5))
                0: x = 32'h80000000;
                1: y = 32'h80000000;
                2: x = $urandom_range(0, 15);
                3: y = 32'hFFFFFFFF;
                default: ;
            endcase
            run_op(x, y, "rand");
        end

        repeat (5) @(posedge clock);
        #1;
        check64("scoreboard_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
